// File: rtl/tile_map_updater.sv
// tile_map_updater: writes tile indices into the packed tile-index RAM, using read-modify-write per tile and a whole-map fill
module tile_map_updater #(
  parameter int TILES_PER_LINE = 100,
  parameter int TILE_LINES = 60,
  parameter int ADDR_WIDTH = 30
) (
  input  logic iCLK_50,
  input  logic iRST_n,
  input  logic i_cmd_valid,
  output logic o_cmd_ready,
  input  logic i_cmd_fill,
  input  logic [6:0] i_cmd_tx,
  input  logic [5:0] i_cmd_ty,
  input  logic [7:0] i_cmd_tile,
  input  logic i_hold,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic o_mem_read,
  input  logic [31:0] i_mem_readdata,
  output logic o_mem_write,
  output logic [31:0] o_mem_writedata,
  output logic o_busy,
  output logic o_err
);
  localparam int NB = TILES_PER_LINE * TILE_LINES;
  localparam int NW = NB / 4;
  localparam int BW = $clog2(NB);
  localparam int CW = $clog2(NW + 1);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, FILL} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0] lane;
  logic [7:0] tile;
  logic [BW-1:0] byte_a;
  logic [31:0] merged;
  logic in_range, accept;
  assign o_cmd_ready = iRST_n && state == IDLE && !i_hold;
  assign accept = i_cmd_valid && o_cmd_ready;
  assign in_range = 32'(i_cmd_tx) < TILES_PER_LINE && 32'(i_cmd_ty) < TILE_LINES;
  assign byte_a = BW'(32'(i_cmd_tx) + 32'(i_cmd_ty) * TILES_PER_LINE);
  assign o_busy = state != IDLE;
  always_comb begin
    merged = i_mem_readdata;
    merged[{lane, 3'b000} +: 8] = tile;
  end
  always_ff @(posedge iCLK_50 or negedge iRST_n)
    if (!iRST_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !accept ? IDLE : i_cmd_fill ? FILL : in_range ? READ : IDLE;
      READ: nxt = WAIT;
      WAIT: nxt = WRITE;
      WRITE: nxt = IDLE;
      FILL: nxt = cnt == CW'(NW) ? IDLE : FILL;
      default: nxt = IDLE;
    endcase
  end
  // cnt is the next fill word to issue; word 0 is issued on the accepting edge
  always_ff @(posedge iCLK_50 or negedge iRST_n)
    if (!iRST_n) begin
      cnt <= '0;
      lane <= '0;
      tile <= '0;
      o_mem_addr <= '0;
      o_mem_read <= 1'b0;
      o_mem_write <= 1'b0;
      o_mem_writedata <= '0;
      o_err <= 1'b0;
    end else begin
      o_mem_read <= 1'b0;
      o_mem_write <= 1'b0;
      o_err <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (i_cmd_fill) begin
            cnt <= CW'(1);
            o_mem_write <= 1'b1;
            o_mem_addr <= '0;
            o_mem_writedata <= {4{i_cmd_tile}};
          end else if (in_range) begin
            tile <= i_cmd_tile;
            lane <= byte_a[1:0];
            o_mem_addr <= ADDR_WIDTH'(byte_a >> 2);
            o_mem_read <= 1'b1;
          end else o_err <= 1'b1;
        end
        WAIT: begin
          o_mem_write <= 1'b1;
          o_mem_writedata <= merged;
        end
        FILL: if (cnt != CW'(NW) && !i_hold) begin
          o_mem_write <= 1'b1;
          o_mem_addr <= ADDR_WIDTH'(cnt);
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_tile_map_updater.sv
// tb_tile_map_updater: table vectors, timing sequences and randomized commands against a word-array model of the tile map
module tb_tile_map_updater;
  localparam int NW = 1500;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_fill = 0, hold = 0;
  logic [6:0] cmd_tx = 0;
  logic [5:0] cmd_ty = 0;
  logic [7:0] cmd_tile = 0;
  logic [29:0] mem_addr;
  logic mem_read, mem_write, busy, err;
  logic [31:0] rdata = 0, wdata;
  logic [31:0] mem [NW];
  logic [31:0] expm [NW];
  logic pre_en = 0, pre_all = 0;
  int pre_addr = 0;
  logic [31:0] pre_data = 0;
  int checks = 0, errors = 0;

  tile_map_updater dut (
    .iCLK_50(clk), .iRST_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_fill(cmd_fill), .i_cmd_tx(cmd_tx), .i_cmd_ty(cmd_ty), .i_cmd_tile(cmd_tile),
    .i_hold(hold), .o_mem_addr(mem_addr), .o_mem_read(mem_read), .i_mem_readdata(rdata),
    .o_mem_write(mem_write), .o_mem_writedata(wdata), .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_all) for (int i = 0; i < NW; i++) mem[i] <= pre_data;
    else if (pre_en) mem[pre_addr] <= pre_data;
    if (mem_write && int'(mem_addr) < NW) mem[int'(mem_addr)] <= wdata;
    if (mem_read) rdata <= int'(mem_addr) < NW ? mem[int'(mem_addr)] : 32'hDEADDEAD;
  end

  typedef struct {
    logic [6:0] tx;
    logic [5:0] ty;
    logic [7:0] tile;
    logic [31:0] init;
    int addr;
    logic [31:0] exp;
    bit err;
  } vec_t;
  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!cmd_ready && n < 5000) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got 0 want 1");
    end
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pre_en = 1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 0;
  endtask

  task automatic preload_all(input logic [31:0] d);
    pre_all = 1; pre_data = d;
    tick();
    pre_all = 0;
  endtask

  task automatic send(input logic f, input logic [6:0] tx, input logic [5:0] ty, input logic [7:0] t);
    int n;
    wait_ready(n);
    cmd_valid = 1; cmd_fill = f; cmd_tx = tx; cmd_ty = ty; cmd_tile = t;
    tick();
    cmd_valid = 0; cmd_fill = 0;
  endtask

  task automatic model_apply(input logic f, input logic [6:0] tx, input logic [5:0] ty, input logic [7:0] t);
    int idx, w, sh;
    if (f) for (int i = 0; i < NW; i++) expm[i] = {4{t}};
    else if (tx < 100 && ty < 60) begin
      idx = tx + ty * 100;
      w = idx / 4;
      sh = (idx % 4) * 8;
      expm[w] = (expm[w] & ~(32'hFF << sh)) | (32'(t) << sh);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    if (!v.err) preload(v.addr, v.init);
    wait_ready(n);
    cmd_valid = 1; cmd_tx = v.tx; cmd_ty = v.ty; cmd_tile = v.tile;
    tick();
    cmd_valid = 0;
    if (v.err) begin
      chk("err_c1", {31'b0, err}, 1);
      chk("err_strobes_c1", {30'b0, mem_read, mem_write}, 0);
      tick();
      chk("err_c2", {29'b0, err, mem_read, mem_write}, 0);
      chk("err_ready_c2", {31'b0, cmd_ready}, 1);
    end else begin
      chk("rd_c1", {30'b0, mem_read, mem_write}, 2);
      chk("rd_addr_c1", {2'b0, mem_addr}, v.addr);
      tick();
      chk("idle_c2", {29'b0, err, mem_read, mem_write}, 0);
      tick();
      chk("wr_c3", {30'b0, mem_read, mem_write}, 1);
      chk("wr_addr_c3", {2'b0, mem_addr}, v.addr);
      chk("wr_data_c3", wdata, v.exp);
      tick();
      chk("ready_c4", {31'b0, cmd_ready}, 1);
      chk("ram_word", mem[v.addr], v.exp);
    end
  endtask

  task automatic run_fill(input logic [7:0] t, input int hold_at, output int cyc, output int gaps, output int bad, output int nw);
    int hc;
    send(1, 0, 0, t);
    cyc = 1; nw = 0; gaps = 0; bad = 0; hc = 0;
    while (!cmd_ready && cyc < 4000) begin
      if (mem_read || !busy) bad++;
      if (mem_write) begin
        if (int'(mem_addr) != nw || wdata != {4{t}}) bad++;
        nw++;
      end else gaps++;
      if (hold_at >= 0 && nw == hold_at && hc == 0) begin
        hold = 1;
        hc = 1;
      end else if (hc >= 1 && hc < 10) hc++;
      else if (hc == 10) begin
        hold = 0;
        hc = 11;
      end
      tick();
      cyc++;
    end
    hold = 0;
  endtask

  initial begin
    int n, cyc, gaps, bad, nw;
    logic f;
    logic [6:0] tx;
    logic [5:0] ty;
    logic [7:0] t;
    vecs[0] = '{7'd5, 6'd2, 8'hAB, 32'h11223344, 51, 32'h1122AB44, 0};
    vecs[1] = '{7'd99, 6'd59, 8'h5A, 32'h11223344, 1499, 32'h5A223344, 0};
    vecs[2] = '{7'd100, 6'd0, 8'h11, 32'h0, 0, 32'h0, 1};
    vecs[3] = '{7'd0, 6'd60, 8'h22, 32'h0, 0, 32'h0, 1};
    vecs[4] = '{7'd3, 6'd0, 8'hC3, 32'hDEADBEEF, 0, 32'hC3ADBEEF, 0};
    vecs[5] = '{7'd0, 6'd1, 8'h00, 32'hFFFFFFFF, 25, 32'hFFFFFF00, 0};
    vecs[6] = '{7'd127, 6'd63, 8'h33, 32'h0, 0, 32'h0, 1};
    tick();
    tick();
    chk("rst_ready", {31'b0, cmd_ready}, 0);
    chk("rst_strobes", {28'b0, busy, err, mem_read, mem_write}, 0);
    chk("rst_addr", {2'b0, mem_addr}, 0);
    chk("rst_wdata", wdata, 0);
    rst_n = 1;
    tick();
    chk("idle_ready", {31'b0, cmd_ready}, 1);
    hold = 1;
    #1;
    chk("hold_idle_ready", {31'b0, cmd_ready}, 0);
    hold = 0;
    #1;
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    // hold raised during READ must not stop the write
    preload(51, 32'h11223344);
    send(0, 5, 2, 8'hAB);
    hold = 1;
    chk("hold_rd_c1", {30'b0, mem_read, mem_write}, 2);
    tick();
    tick();
    chk("hold_wr_c3", {30'b0, mem_read, mem_write}, 1);
    chk("hold_wr_data", wdata, 32'h1122AB44);
    tick();
    chk("hold_ready_c4", {31'b0, cmd_ready}, 0);
    hold = 0;
    #1;
    chk("unhold_ready", {31'b0, cmd_ready}, 1);
    // back-to-back updates into the same word
    preload(0, 32'h0);
    send(0, 0, 0, 8'h01);
    wait_ready(n);
    chk("b2b_gap", n, 3);
    send(0, 1, 0, 8'h02);
    wait_ready(n);
    chk("b2b_word", mem[0], 32'h00000201);
    // plain fill
    run_fill(8'h07, -1, cyc, gaps, bad, nw);
    chk("fill_ready_cyc", cyc, 1501);
    chk("fill_writes", nw, 1500);
    chk("fill_bad", bad, 0);
    chk("fill_gaps", gaps, 0);
    chk("fill_last_word", mem[1499], 32'h07070707);
    // fill with a 10-cycle hold at word 700
    run_fill(8'h5C, 700, cyc, gaps, bad, nw);
    chk("hfill_ready_cyc", cyc, 1511);
    chk("hfill_writes", nw, 1500);
    chk("hfill_bad", bad, 0);
    chk("hfill_gaps", gaps, 10);
    // reset in the middle of a fill
    preload_all(32'h5A5A5A5A);
    send(1, 0, 0, 8'h33);
    nw = 0; cyc = 1;
    while (nw < 300 && cyc < 2000) begin
      if (mem_write) nw++;
      tick();
      cyc++;
    end
    rst_n = 0;
    #1;
    chk("mrst_ready", {31'b0, cmd_ready}, 0);
    chk("mrst_strobes", {28'b0, busy, err, mem_read, mem_write}, 0);
    chk("mrst_addr", {2'b0, mem_addr}, 0);
    chk("mrst_wdata", wdata, 0);
    tick();
    tick();
    rst_n = 1;
    tick();
    bad = 0;
    for (int i = 0; i < NW; i++) if (mem[i] != (i < 300 ? 32'h33333333 : 32'h5A5A5A5A)) bad++;
    chk("mrst_ram", bad, 0);
    run_vec(vecs[0]);
    // randomized commands against the word-array model
    t = 8'($urandom);
    preload_all({4{t}});
    for (int i = 0; i < NW; i++) expm[i] = {4{t}};
    for (int k = 0; k < 60; k++) begin
      f = $urandom_range(0, 24) == 0;
      tx = 7'($urandom_range(0, 110));
      ty = 6'($urandom_range(0, 63));
      t = 8'($urandom);
      send(f, tx, ty, t);
      chk("rnd_err", {31'b0, err}, {31'b0, !f && !(tx < 100 && ty < 60)});
      model_apply(f, tx, ty, t);
      if (!f) for (int j = 0; j < 3; j++) begin
        hold = 1'($urandom);
        tick();
      end
      hold = 0;
      #1;
      wait_ready(n);
    end
    bad = 0;
    for (int i = 0; i < NW; i++) if (mem[i] != expm[i]) bad++;
    chk("rnd_ram_model", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tile_map_updater.md
# tile_map_updater

Write-side companion of the MTL tile display controller. Accepts tile-update commands from the application (Nios/game logic) and writes 8-bit tile indices into the tile-index RAM that the display controller reads, with the same byte packing: byte address = tx + ty*TILES_PER_LINE, word address = byte>>2, lane = byte[1:0] (lane 0 = bits 7:0). The RAM has no byte enables, so single-tile updates are read-modify-write. A fill command clears the whole map.

## Interface
- TILES_PER_LINE, 100, tiles per map row (800 px / 8)
- TILE_LINES, 60, tile rows (480 px / 8); TILES_PER_LINE*TILE_LINES must be divisible by 4
- ADDR_WIDTH, 30, tile-index RAM word-address width

- iCLK_50  in  1  system clock; all logic on rising edge
- iRST_n  in  1  asynchronous, active-low reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when valid & ready
- i_cmd_fill  in  1  1 = fill entire map with i_cmd_tile; tx/ty ignored
- i_cmd_tx  in  7  tile column
- i_cmd_ty  in  6  tile row
- i_cmd_tile  in  8  tile index to write
- i_hold  in  1  blocks new commands and stalls fill (e.g. during active video)
- o_mem_addr  out  ADDR_WIDTH  RAM word address
- o_mem_read  out  1  read strobe; i_mem_readdata valid the following cycle
- i_mem_readdata  in  32  RAM read data
- o_mem_write  out  1  write strobe
- o_mem_writedata  out  32  RAM write data
- o_busy  out  1  state != IDLE
- o_err  out  1  one-cycle pulse: out-of-range command dropped

## Operation
- States: IDLE, READ, WAIT, WRITE, FILL.
- o_cmd_ready = (state==IDLE) & !i_hold; combinational; 0 while iRST_n low.
- IDLE, accept with fill=1: latch tile, word counter <= 0, go FILL.
- IDLE, accept with fill=0 and tx<TILES_PER_LINE, ty<TILE_LINES: latch tile, byte address (13 bits, max 5999), go READ.
- IDLE, accept out of range: o_err=1 next cycle, stay IDLE, no RAM access.
- READ: o_mem_read=1, o_mem_addr=byte>>2 (zero-extended); go WAIT.
- WAIT: register i_mem_readdata; go WRITE.
- WRITE: o_mem_write=1, same address, writedata = captured word with the selected lane replaced by tile, other lanes unchanged; go IDLE.
- The RMW sequence is atomic: i_hold has no effect in READ/WAIT/WRITE.
- FILL: when !i_hold, o_mem_write=1, o_mem_addr=counter, writedata={4{tile}}, counter++. When i_hold=1, no strobe and counter holds. After writing word TILES_PER_LINE*TILE_LINES/4-1 (1499 by default), go IDLE.
- o_mem_read and o_mem_write are never asserted together.
- Reset (any state, any time): state IDLE, counter 0, all strobes deasserted. A partial fill is abandoned and RAM is left as written.

## Timing
- Reset values: o_mem_read=0, o_mem_write=0, o_mem_addr=0, o_mem_writedata=0, o_busy=0, o_err=0.
- Strobes, address and writedata are registered outputs.
- Single update (accept at cycle 0):
  - cycle 1: read strobe
  - cycle 2: data captured
  - cycle 3: write strobe
  - cycle 4: ready again (if !i_hold)
  - Throughput: one update per 4 cycles.
- Fill (accept at cycle 0, no hold): writes on cycles 1..1500, o_cmd_ready returns at cycle 1501. Each held cycle adds one cycle.
- Back-to-back updates to the same word are correct: the read for the second update follows the first update's write.
- o_err is asserted at cycle 1 for exactly one cycle.

## Test plan
- Update tx=5, ty=2, tile=0xAB with RAM word 51 = 0x11223344: read addr 51 at cycle 1, write addr 51 data 0x1122AB44 at cycle 3, ready at cycle 4.
- Fill tile=0x07: 1500 consecutive writes, addr 0..1499, data 0x07070707, no reads, o_busy high throughout, ready at cycle 1501.
- Out of range: tx=100, ty=0 and tx=0, ty=60 each give one o_err pulse and no RAM strobes; tx=99, ty=59 writes addr 1499 lane 3.
- i_hold high for 10 cycles mid-fill at counter 700: no strobes, counter stays 700, total fill takes 1510 cycles. i_hold high in IDLE forces ready=0; i_hold raised during READ does not stop the write at cycle 3.
- Updates (0,0)=0x01 then (1,0)=0x02 back to back on word 0 = 0: final word is 0x00000201.
- iRST_n pulsed low at fill counter 300: outputs go to reset values immediately. A new update after release behaves as in the first scenario and words ≥300 are untouched.
